// File: rtl/universal_register_if.sv
// Control/data bundle for universal_register: the controller side drives
// mode, data and serial inputs; the register side returns q, q_bar and tc.
interface universal_register_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             clear;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sr_in;
  logic             sl_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             tc;

  modport master (
    output en, clear, mode, d, sr_in, sl_in,
    input  q, q_bar, tc
  );

  modport slave (
    input  en, clear, mode, d, sr_in, sl_in,
    output q, q_bar, tc
  );
endinterface

// File: rtl/universal_register.sv
// WIDTH-bit universal register: hold/shift/rotate/load/count with async preset.
// Define UNIREG_COUNT_EN to build the up/down counter and a live tc output.
module universal_register #(
  parameter int                 WIDTH        = 8,
  parameter logic [WIDTH-1:0]   PRESET_VALUE = {WIDTH{1'b0}},
  parameter bit                 INVERT_CLOCK = 1'b0
) (
  input  logic                 s_clock,
  input  logic                 preset,
  universal_register_if.slave  bus
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_INC  = 3'b100;
  localparam logic [2:0] M_DEC  = 3'b101;
  localparam logic [2:0] M_ROR  = 3'b110;
  localparam logic [2:0] M_ROL  = 3'b111;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

`ifdef UNIREG_COUNT_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
`endif

  // clear overrides the enable so a stalled stage can still be zeroed
  always_comb begin
    q_d = q_q;
    if (bus.clear) begin
      q_d = '0;
    end else if (bus.en) begin
      case (bus.mode)
        M_HOLD: q_d = q_q;
        M_SHR:  q_d = {bus.sr_in, q_q[WIDTH-1:1]};
        M_SHL:  q_d = {q_q[WIDTH-2:0], bus.sl_in};
        M_LOAD: q_d = bus.d;
`ifdef UNIREG_COUNT_EN
        M_INC:  q_d = q_q + ONE;
        M_DEC:  q_d = q_q - ONE;
`else
        M_INC:  q_d = q_q;
        M_DEC:  q_d = q_q;
`endif
        M_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        M_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        default: q_d = q_q;
      endcase
    end
  end

  // edge selection lives here so callers never build an inverted clock
  generate
    if (INVERT_CLOCK) begin : g_neg
      always_ff @(negedge s_clock or posedge preset) begin
        if (preset) q_q <= PRESET_VALUE;
        else        q_q <= q_d;
      end
    end else begin : g_pos
      always_ff @(posedge s_clock or posedge preset) begin
        if (preset) q_q <= PRESET_VALUE;
        else        q_q <= q_d;
      end
    end
  endgenerate

  assign bus.q     = q_q;
  assign bus.q_bar = ~q_q;

`ifdef UNIREG_COUNT_EN
  // tc is independent of en so it can feed the next stage's enable
  assign bus.tc = ((bus.mode == M_INC) && (&q_q)) ||
                  ((bus.mode == M_DEC) && (q_q == '0));
`else
  assign bus.tc = 1'b0;
`endif

endmodule

// File: tb/tb_universal_register.sv
// Randomized and directed bench for universal_register (WIDTH=8, preset A5),
// covering both clock polarities and either UNIREG_COUNT_EN build.
module tb_universal_register;

  localparam logic [7:0] PV = 8'hA5;
`ifdef UNIREG_COUNT_EN
  localparam bit COUNT_ON = 1'b1;
`else
  localparam bit COUNT_ON = 1'b0;
`endif

  logic s_clock;
  logic preset0;
  logic preset1;
  int   n_checks;
  int   n_pass;
  int   m_q;

  universal_register_if #(.WIDTH(8)) bus0 ();
  universal_register_if #(.WIDTH(8)) bus1 ();

  universal_register #(.WIDTH(8), .PRESET_VALUE(PV), .INVERT_CLOCK(1'b0)) dut0 (
    .s_clock (s_clock),
    .preset  (preset0),
    .bus     (bus0)
  );

  universal_register #(.WIDTH(8), .PRESET_VALUE(PV), .INVERT_CLOCK(1'b1)) dut1 (
    .s_clock (s_clock),
    .preset  (preset1),
    .bus     (bus1)
  );

  initial begin
    s_clock = 1'b0;
    forever #5 s_clock = ~s_clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Behavioural next-state: integer arithmetic on the value, not bit slicing
  function automatic int ref_next(int q, bit clr, bit en, int mode, int d, bit sr, bit sl);
    if (clr) return 0;
    if (!en) return q;
    case (mode)
      1: return q / 2 + (sr ? 128 : 0);
      2: return (q * 2) % 256 + (sl ? 1 : 0);
      3: return d;
      4: return COUNT_ON ? (q + 1) % 256 : q;
      5: return COUNT_ON ? (q + 255) % 256 : q;
      6: return q / 2 + (q % 2) * 128;
      7: return (q * 2) % 256 + q / 128;
      default: return q;
    endcase
  endfunction

  function automatic int ref_tc(int q, int mode);
    if (!COUNT_ON) return 0;
    return ((mode == 4 && q == 255) || (mode == 5 && q == 0)) ? 1 : 0;
  endfunction

  task automatic step(input string tag, input bit clr, input bit en, input int mode,
                      input int d, input bit sr, input bit sl);
    int exp;
    @(negedge s_clock);
    bus0.clear = clr;
    bus0.en    = en;
    bus0.mode  = 3'(mode);
    bus0.d     = 8'(d);
    bus0.sr_in = sr;
    bus0.sl_in = sl;
    exp = ref_next(m_q, clr, en, mode, d, sr, sl);
    @(posedge s_clock);
    #1;
    m_q = exp;
    chk({tag, ".q"},     32'(bus0.q),     32'(m_q));
    chk({tag, ".q_bar"}, 32'(bus0.q_bar), 32'(255 - m_q));
    chk({tag, ".tc"},    32'(bus0.tc),    32'(ref_tc(m_q, mode)));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    preset0  = 1'b1;
    preset1  = 1'b1;
    {bus0.clear, bus0.en, bus0.mode, bus0.d, bus0.sr_in, bus0.sl_in} = '0;
    {bus1.clear, bus1.en, bus1.mode, bus1.d, bus1.sr_in, bus1.sl_in} = '0;
    #2;
    m_q = 32'(PV);
    chk("rst.q",     32'(bus0.q),     32'h0A5);
    chk("rst.q_bar", 32'(bus0.q_bar), 32'h05A);
    chk("rst.tc",    32'(bus0.tc),    32'(ref_tc(m_q, 0)));

    // edges while preset is high must not load
    bus0.en = 1'b1; bus0.mode = 3'b011; bus0.d = 8'h00;
    @(posedge s_clock); #1;
    chk("preset_hold.q", 32'(bus0.q), 32'h0A5);
    @(negedge s_clock);
    preset0 = 1'b0;
    bus0.en = 1'b0;
    step("hold_en0", 0, 0, 3, 8'h00, 0, 0);
    chk("hold_en0.val", 32'(bus0.q), 32'h0A5);

    step("load81", 0, 1, 3, 8'h81, 0, 0);
    step("shr1", 0, 1, 1, 0, 0, 0);
    step("shr2", 0, 1, 1, 0, 0, 0);
    chk("shr2.val", 32'(bus0.q), 32'h020);
    step("shl1", 0, 1, 2, 0, 0, 1);
    chk("shl1.val", 32'(bus0.q), 32'h041);

    step("load81b", 0, 1, 3, 8'h81, 0, 0);
    step("ror", 0, 1, 6, 0, 0, 0);
    chk("ror.val", 32'(bus0.q), 32'h0C0);
    step("rol1", 0, 1, 7, 0, 0, 0);
    step("rol2", 0, 1, 7, 0, 0, 0);
    chk("rol2.val", 32'(bus0.q), 32'h003);

    step("loadFE", 0, 1, 3, 8'hFE, 0, 0);
    step("inc1", 0, 1, 4, 0, 0, 0);
    step("inc2", 0, 1, 4, 0, 0, 0);
    chk("inc2.val", 32'(bus0.q), COUNT_ON ? 32'h000 : 32'h0FE);

    step("load00", 0, 1, 3, 8'h00, 0, 0);
    @(negedge s_clock);
    bus0.mode = 3'b101;
    #1;
    chk("dec_tc_pre", 32'(bus0.tc), COUNT_ON ? 32'h1 : 32'h0);
    step("dec", 0, 1, 5, 0, 0, 0);
    chk("dec.val", 32'(bus0.q), COUNT_ON ? 32'h0FF : 32'h000);

    step("loadFF", 0, 1, 3, 8'hFF, 0, 0);
    for (int i = 0; i < 3; i++) step("incFF", 0, 1, 4, 0, 0, 0);

    step("clr_pri", 1, 0, 3, 8'hFF, 0, 0);
    chk("clr_pri.val", 32'(bus0.q), 32'h000);

    // preset in the middle of a count aborts it without a clock
    step("load36", 0, 1, 3, 8'h36, 0, 0);
    step("cnt", 0, 1, 4, 0, 0, 0);
    @(negedge s_clock);
    #2;
    preset0 = 1'b1;
    #1;
    m_q = 32'(PV);
    chk("mid_preset.q",     32'(bus0.q),     32'h0A5);
    chk("mid_preset.q_bar", 32'(bus0.q_bar), 32'h05A);
    @(posedge s_clock); #1;
    chk("mid_preset.hold", 32'(bus0.q), 32'h0A5);
    @(negedge s_clock);
    preset0 = 1'b0;

    for (int i = 0; i < 300; i++) begin
      step("rnd", ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    // falling-edge instance: load must land on negedge only
    @(negedge s_clock);
    preset1 = 1'b0;
    @(negedge s_clock);
    #1;
    bus1.en = 1'b1; bus1.mode = 3'b011; bus1.d = 8'h3C;
    @(posedge s_clock); #1;
    chk("inv.posedge", 32'(bus1.q), 32'h0A5);
    @(negedge s_clock); #1;
    chk("inv.negedge", 32'(bus1.q), 32'h03C);
    chk("inv.q_bar",   32'(bus1.q_bar), 32'h0C3);
    bus1.mode = 3'b110;
    @(negedge s_clock); #1;
    chk("inv.ror", 32'(bus1.q), 32'h01E);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/universal_register.md
# universal_register

Parametrised universal register for the ND-120 datapath: a WIDTH-bit state register with asynchronous preset, synchronous clear, clock enable, and eight operating modes (hold, shift, rotate, parallel load, up/down count). It is the multi-bit successor of the single-bit D flip-flop. It replaces discrete 74x194/74x161-style register and counter clusters in the CPU and I/O boards, where shift chains, loadable counters and latches are built from one primitive.

## Interface
- WIDTH, 8: register width in bits, 2..32.
- PRESET_VALUE, {WIDTH{1'b0}}: value forced by `preset`.
- INVERT_CLOCK, 0: 0 = update on rising `s_clock`; 1 = update on falling `s_clock`.

Ports (reset preset, asynchronous, active-high; clock s_clock):
- s_clock  in  1  register clock.
- preset  in  1  asynchronous, active-high; forces state to PRESET_VALUE.
- clear  in  1  synchronous clear to 0; does not depend on `en`.
- en  in  1  clock enable; when 0, state holds (except for `clear`).
- mode  in  3  operation select; see Operation.
- d  in  WIDTH  parallel load data.
- sr_in  in  1  serial input entering the MSB on shift-right.
- sl_in  in  1  serial input entering the LSB on shift-left.
- q  out  WIDTH  register state.
- q_bar  out  WIDTH  bitwise inverse of `q`.
- tc  out  1  terminal count, combinational from `q` and `mode`.

## Operation
Priority on each active edge: `preset` (asynchronous) > `clear` > `en`==0 (hold) > `mode`.

Mode encoding (the next state is written as q'):
- 000 hold: q' = q.
- 001 shift right: q' = {sr_in, q[WIDTH-1:1]}.
- 010 shift left: q' = {q[WIDTH-2:0], sl_in}.
- 011 load: q' = d.
- 100 increment: q' = q+1, modulo 2^WIDTH; all-ones wraps to 0.
- 101 decrement: q' = q-1, modulo 2^WIDTH; 0 wraps to all-ones.
- 110 rotate right: q' = {q[0], q[WIDTH-1:1]}.
- 111 rotate left: q' = {q[WIDTH-2:0], q[WIDTH-1]}.

Output and flag rules:
- tc = 1 when mode==100 and q is all-ones, or when mode==101 and q==0; otherwise 0. `tc` ignores `en`, so it can be cascaded into the next stage's `en`.
- `q_bar` is always ~q and has no separate state.
- Reset values: q = PRESET_VALUE, q_bar = ~PRESET_VALUE. `tc` follows its rule applied to PRESET_VALUE.

## Timing
- Active edge is the rising edge of `s_clock`, or the falling edge if INVERT_CLOCK=1. The inversion is done inside the block, not by the caller.
- Latency: one active edge from the inputs to `q`. `tc` is combinational, zero cycles from `q`/`mode`.
- `preset` assertion takes effect immediately with no clock. While `preset` is high, clock edges are ignored.
- On `preset` deassertion, the first active edge afterwards applies normal priority. An edge coincident with deassertion is not guaranteed to be captured; drive `preset` low at least one cycle before relying on an update.
- `preset` asserted mid-shift or mid-count aborts the operation. No partial state is retained.
- `clear` and `load` in the same cycle: `clear` wins, q' = 0.
- `en`=0 together with `clear`=1: q' = 0.
- Cascading: the upper stage uses `en` = lower.tc and the same `mode`. The carry takes effect on the same edge as the lower stage's wrap.

## Configuration
- Macro UNIREG_COUNT_EN.
- Defined: modes 100/101 count as specified and `tc` is live.
- Undefined: the incrementer/decrementer is not synthesised. Modes 100/101 behave as hold (q' = q) and `tc` is tied to 0.
- All other modes are unaffected in both cases.

## Test plan
- Preset: WIDTH=8, PRESET_VALUE=8'hA5. Assert `preset` between clock edges → q = A5 and q_bar = 5A immediately. Clock edges are ignored while `preset` is high.
- Load, then shift: load d=8'h81. Run mode 001 with sr_in=0 for 2 edges → 20. Run mode 010 with sl_in=1 for 1 edge → 41.
- Rotate: start from q=8'h81. Mode 110 for 1 edge → C0. Mode 111 for 2 edges → 03.
- Count wrap (UNIREG_COUNT_EN defined): start from q=FE in mode 100. After 1 edge q=FF with tc=1; after the next edge q=00 with tc=0. Start from q=00 in mode 101: tc=1, and 1 edge gives FF.
- Priority: `clear`=1, mode=011, d=FF, en=0 → q=00. Assert `preset` mid-count (q=37) → q=PRESET_VALUE asynchronously.
- UNIREG_COUNT_EN undefined: q=FF in mode 100 for 3 edges → q stays FF and tc=0 throughout.
- INVERT_CLOCK=1: load d=3C → q changes only on the falling edge of `s_clock`.
